// File: rtl/reg_counter_param_if.sv
// Control strobes and status outputs of the parametrised counting register.
interface reg_counter_param_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LENW  = 8
);
  logic             clear;
  logic             write_en;
  logic [WIDTH-1:0] datain;
  logic             inc;
  logic             dec;
  logic             burst_start;
  logic [LENW-1:0]  burst_len;
  logic [WIDTH-1:0] dataout;
  logic             at_zero;
  logic             at_limit;
  logic             wrap_evt;
  logic             busy;
  logic             done;

  modport master (
    output clear, write_en, datain, inc, dec, burst_start, burst_len,
    input  dataout, at_zero, at_limit, wrap_evt, busy, done
  );

  modport slave (
    input  clear, write_en, datain, inc, dec, burst_start, burst_len,
    output dataout, at_zero, at_limit, wrap_evt, busy, done
  );
endinterface

// File: rtl/reg_counter_param.sv
// Counting register with bounded range (wrap or saturate), inc/dec, load and
// an autonomous burst-increment mode.
module reg_counter_param #(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      STEP     = 1,
  parameter logic [WIDTH-1:0] LIMIT    = '1,
  parameter bit               SATURATE = 1'b0,
  parameter int unsigned      LENW     = 8
) (
  input logic clk,
  input logic reset,
  reg_counter_param_if.slave bus
);

  typedef enum logic { IDLE, RUN } state_t;

  localparam logic [WIDTH:0] STEP_E = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] MOD_E  = {1'b0, LIMIT} + (WIDTH+1)'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [LENW-1:0]  rem_q, rem_d;
  logic             wrap_q, wrap_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] inc_val, dec_val;
  logic             inc_ovf, dec_unf;

  // Wrapped results are exact modulo 2**WIDTH since they are always <= LIMIT.
  always_comb begin
    sum     = {1'b0, cnt_q} + STEP_E;
    inc_ovf = (sum > {1'b0, LIMIT});
    inc_val = sum[WIDTH-1:0];
    if (inc_ovf) inc_val = SATURATE ? LIMIT : (sum[WIDTH-1:0] - MOD_E[WIDTH-1:0]);

    dec_unf = ({1'b0, cnt_q} < STEP_E);
    dec_val = cnt_q - STEP_E[WIDTH-1:0];
    if (dec_unf) dec_val = SATURATE ? '0 : (cnt_q + MOD_E[WIDTH-1:0] - STEP_E[WIDTH-1:0]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.clear) begin
          cnt_d = '0;
        end else if (bus.write_en) begin
          if (bus.datain > LIMIT) begin
            cnt_d  = LIMIT;
            wrap_d = 1'b1;
          end else begin
            cnt_d = bus.datain;
          end
        end else if (bus.burst_start && (bus.burst_len != '0)) begin
          rem_d   = bus.burst_len;
          state_d = RUN;
        end else if (bus.inc && bus.dec) begin
          cnt_d = cnt_q;
        end else if (bus.inc) begin
          cnt_d  = inc_val;
          wrap_d = inc_ovf;
        end else if (bus.dec) begin
          cnt_d  = dec_val;
          wrap_d = dec_unf;
        end
      end
      RUN: begin
        if (bus.clear) begin
          cnt_d   = '0;
          rem_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d  = inc_val;
          wrap_d = inc_ovf;
          rem_d  = rem_q - LENW'(1);
          if (rem_q == LENW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.dataout  = cnt_q;
  assign bus.at_zero  = (cnt_q == '0);
  assign bus.at_limit = (cnt_q == LIMIT);
  assign bus.wrap_evt = wrap_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_reg_counter_param.sv
// Bench for reg_counter_param: range/flag vectors on two small instances,
// burst sequences on a default-parameter instance.
module tb_reg_counter_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reg_counter_param_if #(.WIDTH(8),  .LENW(8)) ifa ();
  reg_counter_param_if #(.WIDTH(8),  .LENW(8)) ifb ();
  reg_counter_param_if #(.WIDTH(16), .LENW(8)) ifc ();

  reg_counter_param #(.WIDTH(8), .STEP(1), .LIMIT(8'd9), .SATURATE(1'b0), .LENW(8))
    dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  reg_counter_param #(.WIDTH(8), .STEP(4), .LIMIT(8'd9), .SATURATE(1'b1), .LENW(8))
    dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
  reg_counter_param dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

  typedef struct {
    int         sel;
    logic       clr, we, inc, dec;
    logic [7:0] din;
    logic [7:0] exp_d;
    logic       exp_w;
    string      nm;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        w, z, l, busy, done;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ifa.clear = 0; ifa.write_en = 0; ifa.datain = '0; ifa.inc = 0; ifa.dec = 0;
    ifa.burst_start = 0; ifa.burst_len = '0;
    ifb.clear = 0; ifb.write_en = 0; ifb.datain = '0; ifb.inc = 0; ifb.dec = 0;
    ifb.burst_start = 0; ifb.burst_len = '0;
    ifc.clear = 0; ifc.write_en = 0; ifc.datain = '0; ifc.inc = 0; ifc.dec = 0;
    ifc.burst_start = 0; ifc.burst_len = '0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    idle_inputs();
    if (v.sel == 0) begin
      ifa.clear = v.clr; ifa.write_en = v.we; ifa.datain = v.din; ifa.inc = v.inc; ifa.dec = v.dec;
    end else begin
      ifb.clear = v.clr; ifb.write_en = v.we; ifb.datain = v.din; ifb.inc = v.inc; ifb.dec = v.dec;
    end
    e.d = {8'h00, v.exp_d}; e.w = v.exp_w; e.z = (v.exp_d == 8'd0); e.l = (v.exp_d == 8'd9);
    e.busy = 1'b0; e.done = 1'b0; e.nm = v.nm;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    if (v.sel == 0) begin
      check({e.nm, ".dout"}, {8'h00, ifa.dataout}, e.d);
      check({e.nm, ".wrap"}, 16'(ifa.wrap_evt), 16'(e.w));
      check({e.nm, ".zero"}, 16'(ifa.at_zero),  16'(e.z));
      check({e.nm, ".lim"},  16'(ifa.at_limit), 16'(e.l));
    end else begin
      check({e.nm, ".dout"}, {8'h00, ifb.dataout}, e.d);
      check({e.nm, ".wrap"}, 16'(ifb.wrap_evt), 16'(e.w));
      check({e.nm, ".zero"}, 16'(ifb.at_zero),  16'(e.z));
      check({e.nm, ".lim"},  16'(ifb.at_limit), 16'(e.l));
    end
  endtask

  task automatic c_step(input logic rst, input logic clr, input logic we, input logic [15:0] din,
                        input logic bs, input logic [7:0] blen, input logic inc,
                        input logic [15:0] expd, input logic expb, input logic expdone,
                        input string nm);
    exp_t e;
    idle_inputs();
    reset = rst; ifc.clear = clr; ifc.write_en = we; ifc.datain = din;
    ifc.burst_start = bs; ifc.burst_len = blen; ifc.inc = inc;
    e.d = expd; e.busy = expb; e.done = expdone; e.w = 1'b0; e.z = 1'b0; e.l = 1'b0; e.nm = nm;
    sb.push_back(e);
    @(posedge clk); #1;
    reset = 1'b0;
    e = sb.pop_front();
    check({e.nm, ".dout"}, ifc.dataout, e.d);
    check({e.nm, ".busy"}, 16'(ifc.busy), 16'(e.busy));
    check({e.nm, ".done"}, 16'(ifc.done), 16'(e.done));
  endtask

  vec_t vecs[$];

  initial begin
    // sel clr we inc dec din exp_d exp_w name
    vecs = '{
      '{0, 0,1,0,0, 8'd9,   8'd9, 0, "a_wr9"},
      '{0, 0,0,1,0, 8'd0,   8'd0, 1, "a_inc_wrap"},
      '{0, 0,0,0,1, 8'd0,   8'd9, 1, "a_dec_wrap"},
      '{0, 0,0,0,0, 8'd0,   8'd9, 0, "a_hold"},
      '{0, 0,1,0,0, 8'd200, 8'd9, 1, "a_wr_over"},
      '{0, 0,0,1,1, 8'd0,   8'd9, 0, "a_incdec"},
      '{0, 1,1,0,0, 8'd5,   8'd0, 0, "a_clr_we"},
      '{0, 0,1,0,0, 8'd4,   8'd4, 0, "a_wr4"},
      '{0, 0,0,1,0, 8'd0,   8'd5, 0, "a_inc"},
      '{0, 0,0,0,1, 8'd0,   8'd4, 0, "a_dec"},
      '{1, 0,1,0,0, 8'd7,   8'd7, 0, "b_wr7"},
      '{1, 0,0,1,0, 8'd0,   8'd9, 1, "b_inc_sat"},
      '{1, 0,0,1,0, 8'd0,   8'd9, 1, "b_inc_sat2"},
      '{1, 0,1,0,0, 8'd3,   8'd3, 0, "b_wr3"},
      '{1, 0,0,0,1, 8'd0,   8'd0, 1, "b_dec_sat"},
      '{1, 0,0,0,1, 8'd0,   8'd0, 1, "b_dec_sat2"},
      '{1, 0,0,1,0, 8'd0,   8'd4, 0, "b_inc4"},
      '{1, 0,0,1,0, 8'd0,   8'd8, 0, "b_inc8"},
      '{1, 0,0,0,1, 8'd0,   8'd4, 0, "b_dec4"}
    };

    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst.a_dout", {8'h00, ifa.dataout}, 16'd0);
    check("rst.b_zero", 16'(ifb.at_zero), 16'd1);
    check("rst.c_dout", ifc.dataout, 16'd0);
    check("rst.c_busy", 16'(ifc.busy), 16'd0);
    check("rst.c_done", 16'(ifc.done), 16'd0);
    check("rst.c_wrap", 16'(ifc.wrap_evt), 16'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Burst of 5 from 100; inc/write_en during RUN must be ignored.
    c_step(0,0,1,16'd100, 0,8'd0, 0, 16'd100, 0,0, "b5_load");
    c_step(0,0,0,16'd0,   1,8'd5, 1, 16'd100, 1,0, "b5_start");
    for (int k = 1; k <= 4; k++)
      c_step(0,0,(k==3),16'd7, 0,8'd0, (k==2), 16'(100+k), 1,0, "b5_run");
    c_step(0,0,0,16'd0, 0,8'd0, 0, 16'd105, 0,1, "b5_last");
    c_step(0,0,0,16'd0, 0,8'd0, 0, 16'd105, 0,0, "b5_after");

    // Burst of 10 aborted by clear on the third busy cycle.
    c_step(0,0,1,16'd0, 0,8'd0, 0, 16'd0, 0,0, "ab_load");
    c_step(0,0,0,16'd0, 1,8'd10,0, 16'd0, 1,0, "ab_start");
    c_step(0,0,0,16'd0, 0,8'd0, 0, 16'd1, 1,0, "ab_run1");
    c_step(0,0,0,16'd0, 0,8'd0, 0, 16'd2, 1,0, "ab_run2");
    c_step(0,1,0,16'd0, 0,8'd0, 0, 16'd0, 0,0, "ab_clear");
    c_step(0,0,0,16'd0, 0,8'd0, 0, 16'd0, 0,0, "ab_nodone");

    // Same abort via reset.
    c_step(0,0,0,16'd0, 1,8'd10,0, 16'd0, 1,0, "rb_start");
    c_step(0,0,0,16'd0, 0,8'd0, 0, 16'd1, 1,0, "rb_run1");
    c_step(0,0,0,16'd0, 0,8'd0, 0, 16'd2, 1,0, "rb_run2");
    c_step(1,0,0,16'd0, 0,8'd0, 0, 16'd0, 0,0, "rb_reset");
    c_step(0,0,0,16'd0, 0,8'd0, 0, 16'd0, 0,0, "rb_nodone");

    // Zero-length burst is ignored.
    c_step(0,0,0,16'd0, 1,8'd0, 0, 16'd0, 0,0, "z_start");
    c_step(0,0,0,16'd0, 0,8'd0, 0, 16'd0, 0,0, "z_after");

    // Back-to-back bursts of 2, second started in the done cycle.
    c_step(0,0,0,16'd0, 1,8'd2, 0, 16'd0, 1,0, "bb_start1");
    c_step(0,0,0,16'd0, 0,8'd0, 0, 16'd1, 1,0, "bb_run1");
    c_step(0,0,0,16'd0, 0,8'd0, 0, 16'd2, 0,1, "bb_done1");
    c_step(0,0,0,16'd0, 1,8'd2, 0, 16'd2, 1,0, "bb_start2");
    c_step(0,0,0,16'd0, 0,8'd0, 0, 16'd3, 1,0, "bb_run2");
    c_step(0,0,0,16'd0, 0,8'd0, 0, 16'd4, 0,1, "bb_done2");
    c_step(0,0,0,16'd0, 0,8'd0, 0, 16'd4, 0,0, "bb_after");

    // Full-range wrap inside a burst.
    c_step(0,0,1,16'hFFFF, 0,8'd0, 0, 16'hFFFF, 0,0, "fw_load");
    c_step(0,0,0,16'd0,    1,8'd1, 0, 16'hFFFF, 1,0, "fw_start");
    c_step(0,0,0,16'd0,    0,8'd0, 0, 16'h0000, 0,1, "fw_wrap");
    check("fw_wrap.wrap", 16'(ifc.wrap_evt), 16'd1);
    check("fw_wrap.zero", 16'(ifc.at_zero),  16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_counter_param.md
Name: reg_counter_param

Overview:
- Parametrised successor to the 16-bit counting register used for processor address and loop registers (AR, PC, loop counters).
- Adds generic width and step, a programmable upper limit with wrap or saturate mode, decrement, status flags and an autonomous burst-increment mode driven by a two-state FSM.
- Sits in the datapath register set; the control unit drives it with single-cycle control strobes.

Parameters:
WIDTH, 16, data width of datain/dataout
STEP, 1, amount added or subtracted per inc/dec; legal range 1..LIMIT
LIMIT, 2**WIDTH-1, maximum legal value; the count range is 0..LIMIT
SATURATE, 0, overflow mode: 0 = wrap modulo (LIMIT+1), 1 = clamp at LIMIT or 0
LENW, 8, width of burst_len

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-high; clears all state
clear  in  1  synchronous zeroing of dataout; aborts a burst
write_en  in  1  load datain
datain  in  WIDTH  load value
inc  in  1  add STEP
dec  in  1  subtract STEP
burst_start  in  1  begin autonomous burst (IDLE only)
burst_len  in  LENW  number of increments in the burst; sampled with burst_start
dataout  out  WIDTH  registered count value
at_zero  out  1  combinational: dataout == 0
at_limit  out  1  combinational: dataout == LIMIT
wrap_evt  out  1  registered one-cycle pulse: the last update wrapped or clamped
busy  out  1  registered; high while FSM is in RUN
done  out  1  registered one-cycle pulse on burst completion

Behaviour:
- Reset (highest priority, any state): dataout=0, wrap_evt=0, busy=0, done=0, remaining=0, FSM=IDLE.
- Outputs wrap_evt and done default to 0 every cycle unless set by the rules below.
- IDLE priority, highest first:
  - clear: dataout=0.
  - write_en: dataout = min(datain, LIMIT); wrap_evt=1 if datain>LIMIT.
  - burst_start with burst_len!=0: latch remaining=burst_len; FSM=RUN; busy=1; dataout unchanged.
  - inc && dec: hold.
  - inc: apply the increment rule.
  - dec: apply the decrement rule.
  - Otherwise: hold.
- burst_start with burst_len==0 is ignored, with no done pulse. inc/dec asserted in the same cycle as an accepted burst_start are ignored.
- Increment rule, computed in WIDTH+1 bits: s = dataout + STEP.
  - If s <= LIMIT: dataout = s.
  - Else, wrap mode (SATURATE=0): dataout = s - (LIMIT+1).
  - Else, saturate mode (SATURATE=1): dataout = LIMIT.
  - wrap_evt=1 on either overflow case.
- Decrement rule:
  - If dataout >= STEP: dataout = dataout - STEP.
  - Else, wrap mode: dataout = dataout + (LIMIT+1) - STEP.
  - Else, saturate mode: dataout = 0.
  - wrap_evt=1 on either underflow case.
- RUN behaviour:
  - Every edge applies the increment rule and decrements remaining.
  - On the edge where remaining goes 1->0: FSM=IDLE, busy=0, done=1 for the following cycle.
  - A burst of N therefore increments on the N edges after the start edge; busy is high for exactly N cycles; done follows immediately.
- In RUN, write_en, inc, dec and burst_start are ignored.
- clear in RUN: dataout=0, FSM=IDLE, busy=0, remaining=0, no done pulse.
- A new burst_start is accepted in the cycle done is high, since the FSM is already in IDLE.
- Latency: every update is visible on dataout one edge after the strobe. Flags at_zero/at_limit track dataout combinationally.

Test Plan:
1. WIDTH=8, LIMIT=9, STEP=1, SATURATE=0. Write 9, then inc -> dataout=0, wrap_evt pulse, at_zero=1. Then dec -> 9, wrap_evt pulse, at_limit=1.
2. SATURATE=1, STEP=4, LIMIT=9. Write 7, inc -> 9 with wrap_evt; inc again -> 9 with wrap_evt. Write 3, dec -> 0 with wrap_evt.
3. Write datain=200 with LIMIT=9 -> dataout=9, wrap_evt=1. Assert inc and dec together -> dataout holds; assert clear and write_en together -> dataout=0.
4. Default params, dataout=100, burst_start with burst_len=5 -> busy high for 5 cycles; dataout steps 101..105; done pulses one cycle after the final increment; inc during the burst has no effect.
5. Burst of 10 from 0; assert clear on the 3rd busy cycle -> dataout=0, busy=0 next edge, no done pulse. Repeat with reset instead of clear -> identical result. burst_len=0 -> no busy, no done.
6. Back-to-back bursts: burst_len=2, then burst_start again in the done cycle -> second burst accepted; busy re-asserts at the next edge; total increments = 4.
